imem_stream: RTL
================

# imem_stream

Parametrised, loadable instruction memory for the RISC core. A streaming load port, driven by a loader or testbench, writes the program at run time, so the image is not fixed at elaboration. A registered fetch port returns instructions with one-cycle latency, signals faults, and gates the core via `core_run` until a program is fully loaded. The block sits between the boot loader and the core's IF stage.

## Interface
- `DATA_W`, 32, instruction width in bits
- `DEPTH`, 128, number of instruction words; power of two, at least 4
- `ADDR_W`, 32, byte-address width of the fetch port
- `NOP`, 32'h00000013, word returned for unloaded, out-of-range or faulting fetches (`addi x0,x0,0`)

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ld_start`  in  1  one-cycle pulse; begin or restart a program load
- `ld_valid`  in  1  `ld_data` is valid
- `ld_ready`  out  1  block accepts a load word this cycle
- `ld_data`  in  DATA_W  instruction word to write
- `ld_last`  in  1  marks the final word of the program
- `ld_count`  out  $clog2(DEPTH)+1  number of words loaded so far
- `core_run`  out  1  high in RUN; core is allowed to fetch
- `fetch_req`  in  1  fetch request
- `fetch_addr`  in  ADDR_W  byte address of the fetch
- `fetch_valid`  out  1  `fetch_data` and `fetch_fault` are valid
- `fetch_data`  out  DATA_W  fetched instruction
- `fetch_fault`  out  1  misaligned or out-of-range fetch

## Operation
- States: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE → LOAD on `ld_start`.
- RUN → LOAD on `ld_start`. `core_run` drops on the next edge.
- LOAD:
  - `ld_ready` = 1.
  - An accept is `ld_valid` & `ld_ready`. Each accept writes `ld_data` to `mem[ld_count]`, then `ld_count` increments.
  - `ld_start` in LOAD resets `ld_count` to 0. If `ld_start` and an accept coincide, `ld_start` wins and the word is dropped (not written).
  - LOAD → RUN on an accept with `ld_last`=1, or on the accept that makes `ld_count`=DEPTH (overflow guard).
- `ld_ready` = 0 in IDLE and RUN. `ld_valid` is ignored there.
- Fetch requests are honoured only in RUN. In other states `fetch_req` is ignored and `fetch_valid` stays 0.
- Word index = `fetch_addr` >> 2. Priority of fetch responses:
  1. `fetch_addr`[1:0] ≠ 0 → `fetch_data`=NOP, `fetch_fault`=1.
  2. `fetch_addr` ≥ DEPTH*4 → `fetch_data`=NOP, `fetch_fault`=1.
  3. Index ≥ `ld_count` → `fetch_data`=NOP, `fetch_fault`=0. Stale contents are never exposed.
  4. Otherwise `fetch_data`=`mem[index]`, `fetch_fault`=0.
- Memory array is not reset. Contents persist across `rst` but stay hidden because `ld_count` is reset to 0.

## Timing
- Reset values: state=IDLE, `ld_ready`=0, `ld_count`=0, `core_run`=0, `fetch_valid`=0, `fetch_data`=NOP, `fetch_fault`=0.
- `rst` asserted mid-load aborts the load immediately (asynchronous). After release the block is in IDLE with `ld_count`=0.
- `ld_ready` rises the cycle after `ld_start` is sampled. Throughput is one word per cycle.
- `core_run` rises the cycle after the terminating accept.
- Fetch latency is 1 cycle:
  - `fetch_req` sampled at edge N → `fetch_valid`=1 with data after edge N, for exactly one cycle per request.
  - Back-to-back requests give back-to-back responses.
- With no request, `fetch_data` and `fetch_fault` hold their last values and `fetch_valid`=0.
- A `fetch_req` sampled in the same cycle that RUN exits still completes its response.

## Test plan
- Reset, pulse `ld_start`, stream 0x00000093, 0x00100113, 0x002081B3 with `ld_last` on the third word → `ld_count`=3, `core_run`=1 one cycle later.
- In RUN, fetch addresses 0, 4, 8, 12 back-to-back → returns 0x00000093, 0x00100113, 0x002081B3, then NOP with fault 0, on consecutive cycles.
- Fetch 0x6 → NOP with fault 1. Fetch DEPTH*4 (512) → NOP with fault 1.
- Stream DEPTH words without `ld_last` → RUN entered after word 127. Then `ld_ready`=0, and `ld_count` stays 128 while `ld_valid` is held high.
- After 2 words accepted, assert `ld_start` together with an accept → that word is dropped and `ld_count`=0. A new single-word load with `ld_last` gives fetch(4) = NOP.
- Assert `rst` mid-load and mid-RUN → all outputs return to reset values asynchronously, and a fetch before reload gives `fetch_valid`=0.

Source files
------------

// File: rtl/imem_stream_if.sv
// Load and fetch port bundle between the boot loader / core IF stage and imem_stream.
// The master modport is the loader/core side; the slave modport is the memory.
interface imem_stream_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [CNT_W-1:0]  ld_count;
  logic              core_run;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    input  ld_ready, ld_count, core_run, fetch_valid, fetch_data, fetch_fault
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    output ld_ready, ld_count, core_run, fetch_valid, fetch_data, fetch_fault
  );
endinterface

// File: rtl/imem_stream.sv
// Run-time loadable instruction memory: streaming load port, 1-cycle registered fetch port,
// and a core_run gate that opens once a program has been completely loaded.
module imem_stream #(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 128,
  parameter int                ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP    = 32'h00000013
) (
  input logic          clk,
  input logic          rst,
  imem_stream_if.slave bus
);
  localparam int                IDX_W      = $clog2(DEPTH);
  localparam int                CNT_W      = IDX_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);
  localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ld_ready_r;
  logic              core_run_r;
  logic [CNT_W-1:0]  ld_count_r;
  logic              fetch_valid_r;
  logic [DATA_W-1:0] fetch_data_r;
  logic              fetch_fault_r;

  logic              accept_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  fetch_idx_s;
  logic              fetch_misaligned_s;
  logic              fetch_oob_s;
  logic              fetch_unloaded_s;

  assign bus.ld_ready    = ld_ready_r;
  assign bus.core_run    = core_run_r;
  assign bus.ld_count    = ld_count_r;
  assign bus.fetch_valid = fetch_valid_r;
  assign bus.fetch_data  = fetch_data_r;
  assign bus.fetch_fault = fetch_fault_r;

  // Load handshake decode and fetch address classification
  always_comb begin
    accept_s           = (state_r == LOAD) && ld_ready_r && bus.ld_valid;
    // A restart pulse wins over a coincident accept, so that word is never written
    wr_en_s            = accept_s && !bus.ld_start;
    wr_idx_s           = ld_count_r[IDX_W-1:0];
    fetch_idx_s        = bus.fetch_addr[IDX_W+1:2];
    fetch_misaligned_s = (bus.fetch_addr[1:0] != 2'b00);
    fetch_oob_s        = (bus.fetch_addr >= ADDR_LIMIT);
    fetch_unloaded_s   = ({1'b0, fetch_idx_s} >= ld_count_r);
  end

  // Program storage; not reset, ld_count alone decides which words are visible
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= bus.ld_data;
    end
  end

  // Load/run state machine and registered fetch response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ld_ready_r    <= 1'b0;
      core_run_r    <= 1'b0;
      ld_count_r    <= {CNT_W{1'b0}};
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= NOP;
      fetch_fault_r <= 1'b0;
    end else begin
      fetch_valid_r <= 1'b0;
      // Uses the current state, so a request in the cycle RUN is left still completes
      if ((state_r == RUN) && bus.fetch_req) begin
        fetch_valid_r <= 1'b1;
        if (fetch_misaligned_s || fetch_oob_s) begin
          fetch_data_r  <= NOP;
          fetch_fault_r <= 1'b1;
        end else if (fetch_unloaded_s) begin
          fetch_data_r  <= NOP;
          fetch_fault_r <= 1'b0;
        end else begin
          fetch_data_r  <= mem[fetch_idx_s];
          fetch_fault_r <= 1'b0;
        end
      end

      case (state_r)
        IDLE: begin
          if (bus.ld_start) begin
            state_r    <= LOAD;
            ld_ready_r <= 1'b1;
            ld_count_r <= {CNT_W{1'b0}};
          end
        end
        LOAD: begin
          if (bus.ld_start) begin
            ld_count_r <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            ld_count_r <= ld_count_r + CNT_W'(1);
            // Filling the last slot ends the load even without ld_last
            if (bus.ld_last || (ld_count_r == LAST_SLOT)) begin
              state_r    <= RUN;
              ld_ready_r <= 1'b0;
              core_run_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.ld_start) begin
            state_r    <= LOAD;
            ld_ready_r <= 1'b1;
            core_run_r <= 1'b0;
            ld_count_r <= {CNT_W{1'b0}};
          end
        end
        default: begin
          state_r    <= IDLE;
          ld_ready_r <= 1'b0;
          core_run_r <= 1'b0;
          ld_count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end
endmodule
